// File: rtl/ifns_pkg.sv
// Shared defaults, widths and FSM state type for the IFNS bit-serial decoder.
package ifns_pkg;

  localparam int unsigned CW_W_DEF = 31;
  localparam int unsigned DW_DEF   = 22;
  localparam int unsigned IDX_W    = $clog2(CW_W_DEF + 1);
  localparam int unsigned FIB_W    = DW_DEF + 2;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

endpackage

// File: rtl/ifns_fib_weight_gen.sv
// Fibonacci weight pair generator: on init holds F(1),F(2); each step advances the pair by one.
module ifns_fib_weight_gen #(
  parameter int unsigned W = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         init,
  input  logic         step,
  output logic [W-1:0] weight_cur,
  output logic [W-1:0] weight_nxt
);

  logic [W-1:0] fa_q, fa_d;
  logic [W-1:0] fb_q, fb_d;

  always_comb begin
    fa_d = fa_q;
    fb_d = fb_q;
    if (init) begin
      fa_d = W'(1);
      fb_d = W'(1);
    end else if (step) begin
      fa_d = fb_q;
      fb_d = fa_q + fb_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fa_q <= '0;
      fb_q <= '0;
    end else begin
      fa_q <= fa_d;
      fb_q <= fb_d;
    end
  end

  assign weight_cur = fa_q;
  assign weight_nxt = fb_q;

endmodule

// File: rtl/ifns_serial_decode_ctrl.sv
// Bit-serial IFNS codeword decoder: one codeword bit per clock, LSB first, fixed latency.
// Define IFNS_DEC_OVF_EN to add the ovf output and a one-bit-wider accumulator.
module ifns_serial_decode_ctrl
  import ifns_pkg::*;
#(
  parameter int unsigned CW_W = ifns_pkg::CW_W_DEF,
  parameter int unsigned DW   = ifns_pkg::DW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [CW_W-1:0] in_cw,
  input  logic            abort,
  output logic            busy,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   out_value
`ifdef IFNS_DEC_OVF_EN
  ,
  output logic            ovf
`endif
);

  localparam int unsigned IdxW = $clog2(CW_W + 1);
  localparam int unsigned FibW = DW + 2;
`ifdef IFNS_DEC_OVF_EN
  localparam int unsigned AccW = DW + 1;
`else
  localparam int unsigned AccW = DW;
`endif

  state_e            state_q, state_d;
  logic [CW_W-1:0]   sr_q, sr_d;
  logic [AccW-1:0]   acc_q, acc_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic              fib_init, fib_step;
  logic [FibW-1:0]   weight_cur, weight_nxt, weight;
  logic              last;

  ifns_fib_weight_gen #(
    .W (FibW)
  ) u_fib (
    .clk        (clk),
    .rst        (rst),
    .init       (fib_init),
    .step       (fib_step),
    .weight_cur (weight_cur),
    .weight_nxt (weight_nxt)
  );

  assign last   = (idx_q == IdxW'(CW_W));
  // The top codeword bit is weighted F(CW_W+1), one step ahead of the running index.
  assign weight = last ? weight_nxt : weight_cur;

`ifdef IFNS_DEC_OVF_EN
  logic              ovf_q, ovf_d;
  logic [FibW:0]     sum_ext;
  logic [AccW-1:0]   acc_sum;
  logic              step_carry;

  assign sum_ext    = (FibW + 1)'(acc_q) + (FibW + 1)'(weight);
  assign acc_sum    = sum_ext[AccW-1:0];
  assign step_carry = |sum_ext[FibW:AccW];
`else
  logic [AccW-1:0]   acc_sum;

  assign acc_sum = acc_q + AccW'(weight);
`endif

  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
    fib_init = 1'b0;
    fib_step = 1'b0;
`ifdef IFNS_DEC_OVF_EN
    ovf_d    = ovf_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          sr_d     = in_cw;
          acc_d    = '0;
          idx_d    = IdxW'(1);
          fib_init = 1'b1;
`ifdef IFNS_DEC_OVF_EN
          ovf_d    = 1'b0;
`endif
          state_d  = StRun;
        end
      end
      StRun: begin
        if (abort) begin
          state_d = StIdle;
        end else begin
          if (sr_q[0]) begin
            acc_d = acc_sum;
`ifdef IFNS_DEC_OVF_EN
            ovf_d = ovf_q | step_carry;
`endif
          end
          sr_d     = sr_q >> 1;
          fib_step = 1'b1;
          idx_d    = idx_q + IdxW'(1);
          if (last) state_d = StDone;
        end
      end
      StDone: begin
        if (abort || out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      sr_q    <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
    end
  end

`ifdef IFNS_DEC_OVF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign ovf = (state_q == StDone) && (ovf_q || acc_q[DW]);
`endif

  assign in_ready  = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign out_valid = (state_q == StDone);
  assign out_value = acc_q[DW-1:0];

endmodule

// File: tb/tb_ifns_serial_decode_ctrl.sv
// Self-checking bench for ifns_serial_decode_ctrl: directed cases plus random codewords
// compared against a Fibonacci-sum reference model.
module tb_ifns_serial_decode_ctrl;

  localparam int unsigned CW_W = 31;
  localparam int unsigned DW   = 22;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [CW_W-1:0] in_cw = '0;
  logic            abort = 1'b0;
  logic            busy;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [DW-1:0]   out_value;
`ifdef IFNS_DEC_OVF_EN
  logic            ovf;
`endif

  int checks = 0;
  int errors = 0;

  ifns_serial_decode_ctrl #(
    .CW_W (CW_W),
    .DW   (DW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_cw     (in_cw),
    .abort     (abort),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_value (out_value)
`ifdef IFNS_DEC_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // True (unbounded) weighted sum: bit k (1-based) weighs F(k), the top bit weighs F(CW_W+1).
  function automatic longint unsigned ref_sum(input logic [CW_W-1:0] cw);
    longint unsigned f [0:CW_W+1];
    longint unsigned s;
    f[0] = 0;
    f[1] = 1;
    f[2] = 1;
    for (int k = 3; k <= CW_W + 1; k++) f[k] = f[k-1] + f[k-2];
    s = 0;
    for (int k = 1; k < CW_W; k++) if (cw[k-1]) s += f[k];
    if (cw[CW_W-1]) s += f[CW_W+1];
    return s;
  endfunction

  task automatic wait_done(input string tag, output int n);
    n = 0;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
    chk({tag, " latency"}, 64'(n), 64'(CW_W));
  endtask

  task automatic decode(input logic [CW_W-1:0] cw, input int hold, input bit noisy,
                        input string tag);
    longint unsigned s;
    logic [DW-1:0]   ev;
    int              n;
    s  = ref_sum(cw);
    ev = DW'(s % (64'd1 << DW));
    n  = 0;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    chk({tag, " in_ready idle"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    in_cw    = cw;
    tick();
    in_valid = 1'b0;
    in_cw    = '0;
    chk({tag, " busy/in_ready run"}, {62'd0, busy, in_ready}, 64'b10);
    n = 0;
    while (!out_valid && n < 100) begin
      if (noisy) begin
        in_valid = 1'($urandom_range(0, 1));
        in_cw    = CW_W'($urandom);
      end
      tick();
      n++;
    end
    in_valid = 1'b0;
    chk({tag, " latency"}, 64'(n), 64'(CW_W));
    chk({tag, " value"}, 64'(out_value), 64'(ev));
`ifdef IFNS_DEC_OVF_EN
    chk({tag, " ovf"}, 64'(ovf), 64'(s >= (64'd1 << DW)));
`endif
    for (int i = 0; i < hold; i++) begin
      tick();
      chk({tag, " hold"}, {out_valid, in_ready, 40'd0, out_value}, {1'b1, 1'b0, 40'd0, ev});
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, " release"}, {62'd0, out_valid, in_ready}, 64'b01);
  endtask

  initial begin
    int  n;
    bit  seen;
    logic [CW_W-1:0] cw;

    // Reset state
    #12;
    chk("reset outputs", {60'd0, in_ready, busy, out_valid, |out_value}, 64'b1000);
`ifdef IFNS_DEC_OVF_EN
    chk("reset ovf", 64'(ovf), 64'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Directed values
    decode(31'd1, 0, 1'b0, "d1");
    decode(31'(1) << 29, 0, 1'b0, "d30");
    decode(31'(1) << 30, 0, 1'b0, "d31");
    chk("d31 model", ref_sum(31'(1) << 30), 64'd2178309);
    decode(31'h7FFF_FFFF, 0, 1'b0, "all ones");
    decode(31'b101, 10, 1'b0, "hold101");

    // Abort at idx 12: nothing is produced, and the next decode is clean
    in_valid = 1'b1;
    in_cw    = 31'h5555_5555;
    tick();
    in_valid = 1'b0;
    repeat (11) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort run -> idle", {61'd0, in_ready, busy, out_valid}, 64'b100);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      seen |= out_valid;
    end
    chk("abort no out_valid", 64'(seen), 64'd0);
    decode(31'h4, 0, 1'b0, "after abort");

    // abort together with out_ready in DONE
    in_valid = 1'b1;
    in_cw    = 31'h3;
    tick();
    in_valid = 1'b0;
    wait_done("abort done", n);
    abort     = 1'b1;
    out_ready = 1'b1;
    tick();
    abort     = 1'b0;
    out_ready = 1'b0;
    chk("abort done -> idle", {62'd0, out_valid, in_ready}, 64'b01);

    // abort in IDLE is ignored: the codeword is still accepted
    abort    = 1'b1;
    in_valid = 1'b1;
    in_cw    = 31'h1;
    tick();
    abort    = 1'b0;
    in_valid = 1'b0;
    chk("abort idle ignored", 64'(busy), 64'd1);
    wait_done("idle abort decode", n);
    chk("idle abort value", 64'(out_value), 64'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Asynchronous reset mid-RUN
    in_valid = 1'b1;
    in_cw    = 31'h7F;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    #1;
    chk("async reset", {60'd0, in_ready, busy, out_valid, |out_value}, 64'b1000);
    tick();
    rst = 1'b0;
    decode(31'h0, 0, 1'b0, "post reset zero");
    decode(31'h9, 0, 1'b0, "post reset b2b");

    // Randomized codewords, some with noise on in_valid/in_cw during the decode
    for (int i = 0; i < 12; i++) begin
      cw = CW_W'($urandom);
      if (i % 3 == 0) cw = cw | (31'h7 << 28);
      decode(cw, int'($urandom_range(0, 3)), 1'(i % 2), "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
